configs_loader: RTL and testbench



---
 rtl/configs_loader.sv | 101 ++++++++++
 tb/tb_configs_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/configs_loader.sv
// Streams configuration words into a level-sensitive latch bank using a
// setup/strobe/hold sequence, so the data bus is stable while any enable is high.
module configs_loader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 34,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_cfg_valid,
  output logic                 io_cfg_ready,
  input  logic [WORD_W-1:0]    io_cfg_data,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic [IDX_W-1:0]     io_word_idx,
  output logic                 io_busy,
  output logic                 io_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [NUM_WORDS-1:0] EN_ONE   = NUM_WORDS'(1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             hs;

  // Ready is a registered decode of WAIT, so this matches valid & ready.
  assign hs = (state == S_WAIT) && io_cfg_valid;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    idx_nxt   = io_word_idx;
    case (state)
      S_IDLE: begin
        if (io_start) begin
          state_nxt = S_WAIT;
          idx_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (io_start) idx_nxt = '0;
        if (hs)       state_nxt = S_SETUP;
      end
      S_SETUP:  state_nxt = S_STROBE;
      S_STROBE: state_nxt = S_HOLD;
      S_HOLD: begin
        if (io_word_idx == LAST_IDX) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_WAIT;
          idx_nxt   = io_word_idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (io_start) begin
          state_nxt = S_WAIT;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each one lines up with the
  // state it describes and nothing downstream sees combinational glitches.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge
    // values, independent of statement order.
    if (reset) begin
      state         <= S_IDLE;
      io_word_idx   <= '0;
      io_d_out      <= '0;
      io_configs_en <= '0;
      io_cfg_ready  <= 1'b0;
      io_busy       <= 1'b0;
      io_done       <= 1'b0;
    end else begin
      state         <= state_nxt;
      io_word_idx   <= idx_nxt;
      io_cfg_ready  <= (state_nxt == S_WAIT);
      io_busy       <= (state_nxt == S_WAIT) || (state_nxt == S_SETUP) ||
                       (state_nxt == S_STROBE) || (state_nxt == S_HOLD);
      io_done       <= (state_nxt == S_DONE);
      io_configs_en <= (state_nxt == S_STROBE) ? (EN_ONE << idx_nxt) : '0;
      if (hs) io_d_out <= io_cfg_data;
    end
  end

endmodule

// File: tb/tb_configs_loader.sv
// Self-checking bench for configs_loader: a scoreboard of accepted words is
// matched against each enable pulse, and a latch-bank model is compared after each load.
module tb_configs_loader;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 34;
  localparam int IDX_W     = 6;

  logic                 clk;
  logic                 reset;
  logic                 io_start;
  logic                 io_cfg_valid;
  logic                 io_cfg_ready;
  logic [WORD_W-1:0]    io_cfg_data;
  logic [WORD_W-1:0]    io_d_out;
  logic [NUM_WORDS-1:0] io_configs_en;
  logic [IDX_W-1:0]     io_word_idx;
  logic                 io_busy;
  logic                 io_done;

  configs_loader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_start     (io_start),
    .io_cfg_valid (io_cfg_valid),
    .io_cfg_ready (io_cfg_ready),
    .io_cfg_data  (io_cfg_data),
    .io_d_out     (io_d_out),
    .io_configs_en(io_configs_en),
    .io_word_idx  (io_word_idx),
    .io_busy      (io_busy),
    .io_done      (io_done)
  );

  typedef struct {
    int          slot;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] bank[NUM_WORDS];
  logic [31:0] ref_words[NUM_WORDS];
  int          n_checks = 0;
  int          n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: pops the scoreboard, updates the latch model, checks bus stability.
  logic [31:0] prev_d  = '0;
  logic        prev_en = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   pos;
    if (!reset) begin
      if (io_configs_en != '0) begin
        check("en_onehot", 64'($countones(io_configs_en)), 1);
        check("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e   = sb.pop_front();
          pos = 0;
          for (int b = 0; b < NUM_WORDS; b++) if (io_configs_en[b]) pos = b;
          check("en_slot", 64'(pos), 64'(e.slot));
          check("strobe_data", io_d_out, e.data);
          bank[pos] = io_d_out;
        end
        check("d_stable_before", io_d_out, prev_d);
      end else if (prev_en) begin
        check("d_stable_after", io_d_out, prev_d);
      end
    end
    prev_d  = io_d_out;
    prev_en = |io_configs_en;
  end

  task automatic pulse_start();
    io_start = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
  endtask

  // Offers one word (after an optional gap) and returns how many negedges it
  // waited for ready; always ends one negedge after the handshake.
  task automatic send_word(input logic [31:0] d, input int slot, input int gap, output int t);
    if (gap > 0) begin
      io_cfg_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    io_cfg_valid = 1'b1;
    io_cfg_data  = d;
    t = 0;
    while (!io_cfg_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("hs_timeout", 64'(t >= 200), 0);
    if (t < 200) begin
      check("word_idx", 64'(io_word_idx), 64'(slot));
      sb.push_back('{slot: slot, data: d});
    end
    @(negedge clk);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!io_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(n >= 300), 0);
  endtask

  // Loads ref_words into slots 0..N-1; elapsed counts cycles from the first
  // handshake cycle to the cycle where io_done is first seen.
  task automatic load_all(input int max_gap, output int elapsed);
    int t;
    int g;
    elapsed = 0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      g = (i == 0 || max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
      send_word(ref_words[i], i, g, t);
      if (i > 0) elapsed += g + t;
      elapsed += 1;
    end
    io_cfg_valid = 1'b0;
    wait_done(t);
    elapsed += t;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NUM_WORDS; i++) check(tag, bank[i], ref_words[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int el;
    int t;
    reset        = 1'b1;
    io_start     = 1'b0;
    io_cfg_valid = 1'b0;
    io_cfg_data  = '0;
    for (int i = 0; i < NUM_WORDS; i++) bank[i] = '0;

    // Reset, then valid with no start must be ignored.
    repeat (2) @(negedge clk);
    check("rst_d_out", io_d_out, 0);
    check("rst_en", 64'(io_configs_en), 0);
    check("rst_ready", 64'(io_cfg_ready), 0);
    check("rst_idx", 64'(io_word_idx), 0);
    check("rst_busy", 64'(io_busy), 0);
    check("rst_done", 64'(io_done), 0);
    reset        = 1'b0;
    io_cfg_valid = 1'b1;
    io_cfg_data  = 32'hDEAD_BEEF;
    repeat (10) begin
      @(negedge clk);
      check("idle_ready", 64'(io_cfg_ready), 0);
      check("idle_en", 64'(io_configs_en), 0);
      check("idle_d_out", io_d_out, 0);
    end
    io_cfg_valid = 1'b0;

    // Full load with continuous valid.
    for (int i = 0; i < NUM_WORDS; i++) ref_words[i] = 32'hA500_0000 + 32'(i);
    pulse_start();
    load_all(0, el);
    check("full_load_cycles", 64'(el), 136);
    check("full_done", 64'(io_done), 1);
    check("full_busy", 64'(io_busy), 0);
    check("full_ready", 64'(io_cfg_ready), 0);
    check_bank("full_bank");

    // Reload from DONE with all-ones words.
    pulse_start();
    check("reload_done_clr", 64'(io_done), 0);
    check("reload_busy", 64'(io_busy), 1);
    check("reload_ready", 64'(io_cfg_ready), 1);
    for (int i = 0; i < NUM_WORDS; i++) ref_words[i] = 32'hFFFF_FFFF;
    load_all(0, el);
    check("reload_cycles", 64'(el), 136);
    check_bank("reload_bank");

    // Random data with random valid gaps.
    for (int i = 0; i < NUM_WORDS; i++) ref_words[i] = $urandom;
    pulse_start();
    load_all(7, el);
    check("gap_done", 64'(io_done), 1);
    check_bank("gap_bank");

    // Restart while waiting after 5 words.
    pulse_start();
    for (int i = 0; i < 5; i++) send_word(32'h1111_0000 + 32'(i), i, 0, t);
    io_cfg_valid = 1'b0;
    t = 0;
    while (!io_cfg_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("restart_wait_timeout", 64'(t >= 20), 0);
    check("restart_sb_drained", 64'(sb.size()), 0);
    check("restart_idx_before", 64'(io_word_idx), 5);
    pulse_start();
    check("restart_idx", 64'(io_word_idx), 0);
    check("restart_ready", 64'(io_cfg_ready), 1);
    check("restart_done", 64'(io_done), 0);
    for (int i = 0; i < NUM_WORDS; i++) ref_words[i] = 32'h2222_0000 + 32'(i);
    load_all(0, el);
    check("restart_cycles", 64'(el), 136);
    check_bank("restart_bank");

    // Reset during the strobe of word 7.
    pulse_start();
    for (int i = 0; i < 8; i++) send_word(32'h3333_0000 + 32'(i), i, 0, t);
    io_cfg_valid = 1'b0;
    t = 0;
    while (!io_configs_en[7] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("strobe7_timeout", 64'(t >= 20), 0);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_en", 64'(io_configs_en), 0);
    check("midrst_busy", 64'(io_busy), 0);
    check("midrst_ready", 64'(io_cfg_ready), 0);
    check("midrst_d_out", io_d_out, 0);
    check("midrst_idx", 64'(io_word_idx), 0);
    check("midrst_bank7", bank[7], 32'h3333_0007);
    check("midrst_bank8", bank[8], 32'h2222_0008);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NUM_WORDS; i++) ref_words[i] = 32'h4444_0000 + 32'(i);
    pulse_start();
    load_all(3, el);
    check("post_rst_done", 64'(io_done), 1);
    check_bank("post_rst_bank");
    check("sb_final_empty", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
